// File: rtl/norm_sched.sv
// Round-robin issue scheduler sharing one norm_stage datapath among four FPU lanes.
// Tracks lane ownership through a tag pipeline and keeps saturating zero/denormal counters.

module norm_sched_lane #(
  parameter int MAX_OUT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       vld,
  input  logic       inc,
  input  logic       dec,
  output logic       elig,
  output logic [1:0] cnt
);
  // Credit check uses the registered count; a same-cycle decrement is seen next cycle.
  assign elig = vld && !flush && !rst && (cnt < 2'(MAX_OUT));

  always_ff @(posedge clk) begin
    if (rst || flush)                     cnt <= '0;
    else if (inc && !dec && cnt != 2'd3)  cnt <= cnt + 2'd1;
    else if (dec && !inc && cnt != 2'd0)  cnt <= cnt - 2'd1;
  end
endmodule

module norm_sched #(
  parameter int NORM_LAT = 2,
  parameter int MAX_OUT  = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic [3:0]   req_vld,
  output logic [3:0]   req_rdy,
  input  logic [3:0]   req_s_tmp,
  input  logic [3:0]   req_final_m,
  input  logic [3:0]   req_h_s,
  input  logic [39:0]  req_exp,
  input  logic [299:0] req_frac,
  output logic         iss_vld,
  output logic         iss_s_tmp,
  output logic         iss_final_m,
  output logic         iss_h_s,
  output logic [9:0]   iss_exp,
  output logic [74:0]  iss_frac,
  input  logic         dp_zero_m,
  input  logic         dp_denorm_m,
  output logic [3:0]   res_vld,
  output logic [15:0]  zero_cnt,
  output logic [15:0]  denorm_cnt,
  output logic         busy
);
  localparam int NUM_LANES = 4;

  logic [1:0]                  ptr;
  logic [NUM_LANES-1:0]        elig;
  logic [NUM_LANES-1:0][1:0]   out_cnt;
  logic                        found;
  logic [1:0]                  gnt_lane;
  logic [1:0]                  scan_idx;
  // Stage 0 loads alongside the issue register, so NORM_LAT+1 stages land the tail at T+1+NORM_LAT.
  logic [NORM_LAT:0]           vld_pipe;
  logic [NORM_LAT:0][1:0]      lane_pipe;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      norm_sched_lane #(.MAX_OUT(MAX_OUT)) u_lane (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .vld  (req_vld[i]),
        .inc  (req_rdy[i]),
        .dec  (res_vld[i]),
        .elig (elig[i]),
        .cnt  (out_cnt[i])
      );
    end
  endgenerate

  always_comb begin
    found    = 1'b0;
    gnt_lane = ptr;
    scan_idx = ptr;
    req_rdy  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      scan_idx = ptr + 2'(k);
      if (!found && elig[scan_idx]) begin
        found    = 1'b1;
        gnt_lane = scan_idx;
      end
    end
    req_rdy[gnt_lane] = found;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_vld     <= 1'b0;
      iss_s_tmp   <= 1'b0;
      iss_final_m <= 1'b0;
      iss_h_s     <= 1'b0;
      iss_exp     <= '0;
      iss_frac    <= '0;
      ptr         <= '0;
    end else begin
      iss_vld <= found;
      if (found) begin
        iss_s_tmp   <= req_s_tmp[gnt_lane];
        iss_final_m <= req_final_m[gnt_lane];
        iss_h_s     <= req_h_s[gnt_lane];
        iss_exp     <= req_exp[gnt_lane*10 +: 10];
        iss_frac    <= req_frac[gnt_lane*75 +: 75];
        ptr         <= gnt_lane + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      lane_pipe <= '0;
    end else begin
      vld_pipe  <= flush ? '0 : {vld_pipe[NORM_LAT-1:0], found};
      lane_pipe <= {lane_pipe[NORM_LAT-1:0], gnt_lane};
    end
  end

  always_comb begin
    res_vld = '0;
    if (vld_pipe[NORM_LAT] && !flush && !rst) res_vld[lane_pipe[NORM_LAT]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_cnt   <= '0;
      denorm_cnt <= '0;
    end else if (|res_vld) begin
      if (dp_zero_m && zero_cnt != 16'hFFFF)     zero_cnt   <= zero_cnt + 16'd1;
      if (dp_denorm_m && denorm_cnt != 16'hFFFF) denorm_cnt <= denorm_cnt + 16'd1;
    end
  end

  assign busy = iss_vld | (|vld_pipe);
endmodule
